// File: rtl/pcihellocore_led_sequencer.sv
// LED sequencer: Avalon-MM slave owning the board LEDs. In IDLE it behaves as a
// plain PIO (PATTERN writes drive the LEDs). In RUN it steps the LED register
// through a static, blink, rotate or bounce pattern every PERIOD cycles,
// optionally halting after a programmed number of steps.
//
// Bus handshake: the slave has zero wait states. A write is accepted on every
// clock edge where chipselect && !write_n. Reads have no side effects, and
// readdata is a combinational decode of address over the registered state.
`timescale 1ns/1ps

module pcihellocore_led_sequencer #(
   parameter int          WIDTH          = 32,
   parameter logic [31:0] RESET_PATTERN  = 32'd255,
   parameter logic [31:0] DEFAULT_PERIOD = 32'd50000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_ROTL   = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;

   localparam logic [WIDTH-1:0] RESET_CUR = RESET_PATTERN[WIDTH-1:0];

   state_t           state_q, state_d;
   logic             ctrl_en_q, ctrl_en_d;
   logic [1:0]       ctrl_mode_q, ctrl_mode_d;
   logic [15:0]      ctrl_steps_q, ctrl_steps_d;
   logic [31:0]      period_q, period_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [31:0]      tick_q, tick_d;
   logic [15:0]      steps_done_q, steps_done_d;
   logic             done_q, done_d;
   logic             dir_q, dir_d;       // 0 = moving left, 1 = moving right

   logic             wr;
   logic             wr_ctrl, wr_period, wr_pattern;
   logic [31:0]      period_eff;
   logic             step;
   logic [WIDTH-1:0] step_cur;
   logic             step_dir;
   logic [15:0]      steps_done_inc;

   assign wr         = chipselect && !write_n;
   assign wr_ctrl    = wr && (address == 3'd0);
   assign wr_period  = wr && (address == 3'd1);
   assign wr_pattern = wr && (address == 3'd2);

   // A period of zero behaves as one cycle per step.
   assign period_eff     = (period_q == 32'd0) ? 32'd1 : period_q;
   assign step           = (state_q == S_RUN) && (tick_q == period_eff - 32'd1);
   assign steps_done_inc = steps_done_q + 16'd1;

   assign out_port = cur_q;

   // Compute the LED value and bounce direction one step would produce.
   always_comb begin
      step_cur = cur_q;
      step_dir = dir_q;
      case (ctrl_mode_q)
         MODE_BLINK: step_cur = cur_q ^ pattern_q;
         MODE_ROTL:  step_cur = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
         MODE_BOUNCE: begin
            if (!dir_q) begin
               if (cur_q[WIDTH-1]) begin
                  step_dir = 1'b1;
                  step_cur = cur_q >> 1;
               end else begin
                  step_cur = cur_q << 1;
               end
            end else begin
               if (cur_q[0]) begin
                  step_dir = 1'b0;
                  step_cur = cur_q << 1;
               end else begin
                  step_cur = cur_q >> 1;
               end
            end
         end
         default: step_cur = cur_q;   // MODE_STATIC: timer only
      endcase
   end

   // Next-state and register-update logic; a CTRL write always overrides a step.
   always_comb begin
      state_d      = state_q;
      ctrl_en_d    = ctrl_en_q;
      ctrl_mode_d  = ctrl_mode_q;
      ctrl_steps_d = ctrl_steps_q;
      period_d     = period_q;
      pattern_d    = pattern_q;
      cur_d        = cur_q;
      tick_d       = tick_q;
      steps_done_d = steps_done_q;
      done_d       = done_q;
      dir_d        = dir_q;

      if (wr_ctrl) begin
         ctrl_en_d    = writedata[0];
         ctrl_mode_d  = writedata[2:1];
         ctrl_steps_d = writedata[31:16];
      end
      if (wr_period) begin
         period_d = writedata;
      end
      if (wr_pattern) begin
         pattern_d = writedata[WIDTH-1:0];
      end

      if (wr_ctrl) begin
         cur_d = pattern_q;
         if (writedata[0]) begin
            state_d      = S_RUN;
            tick_d       = 32'd0;
            steps_done_d = 16'd0;
            done_d       = 1'b0;
            dir_d        = 1'b0;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_pattern) begin
                  cur_d = writedata[WIDTH-1:0];
               end
            end
            S_RUN: begin
               tick_d = tick_q + 32'd1;
               if (step) begin
                  tick_d       = 32'd0;
                  steps_done_d = steps_done_inc;
                  cur_d        = step_cur;
                  dir_d        = step_dir;
                  if ((ctrl_steps_q != 16'd0) && (steps_done_inc == ctrl_steps_q)) begin
                     state_d = S_HALT;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               // S_HALT: hold everything until software writes CTRL.
            end
         endcase
      end

      // A new period always restarts the step timer, so shortening the period
      // never waits for the 32-bit counter to wrap.
      if (wr_period) begin
         tick_d = 32'd0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Control, pattern and sequencing registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_en_q    <= 1'b0;
         ctrl_mode_q  <= 2'd0;
         ctrl_steps_q <= 16'd0;
         period_q     <= DEFAULT_PERIOD;
         pattern_q    <= RESET_CUR;
         cur_q        <= RESET_CUR;
         tick_q       <= 32'd0;
         steps_done_q <= 16'd0;
         done_q       <= 1'b0;
         dir_q        <= 1'b0;
      end else begin
         ctrl_en_q    <= ctrl_en_d;
         ctrl_mode_q  <= ctrl_mode_d;
         ctrl_steps_q <= ctrl_steps_d;
         period_q     <= period_d;
         pattern_q    <= pattern_d;
         cur_q        <= cur_d;
         tick_q       <= tick_d;
         steps_done_q <= steps_done_d;
         done_q       <= done_d;
         dir_q        <= dir_d;
      end
   end

   // Read decode; unmapped addresses and unused bits read as zero.
   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0: readdata = {ctrl_steps_q, 13'd0, ctrl_mode_q, ctrl_en_q};
         3'd1: readdata = period_q;
         3'd2: readdata[WIDTH-1:0] = pattern_q;
         3'd3: readdata = {steps_done_q, 14'd0, done_q, (state_q == S_RUN)};
         3'd4: readdata[WIDTH-1:0] = cur_q;
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_pcihellocore_led_sequencer.sv
// Bench for the LED sequencer, built with WIDTH=8. Register-access vectors come
// from a table; sequencing behaviour is compared against a step-count model and
// hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_pcihellocore_led_sequencer;

   localparam int W = 8;

   logic          clk;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        do_wr;
      logic [2:0]  wr_addr;
      logic [31:0] wr_data;
      logic [2:0]  rd_addr;
      logic [31:0] exp_rd;
      logic [W-1:0] exp_led;
   } vec_t;

   vec_t tbl[17];

   pcihellocore_led_sequencer #(
      .WIDTH(W),
      .RESET_PATTERN(32'd255),
      .DEFAULT_PERIOD(32'd50000000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .out_port(out_port)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cycle();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: compare the current LED value with the oldest expectation
   task automatic sb_check(input string name);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %h expected <empty queue>", name, out_port);
      end else begin
         e = exp_q.pop_front();
         check(name, {24'd0, out_port}, {24'd0, e});
      end
   endtask

   // reference model: LED value after n steps from a fresh start
   function automatic logic [W-1:0] model_cur(input int mode, input logic [W-1:0] pat, input int n);
      logic [W-1:0] c;
      bit right;
      int v, r;
      c = pat;
      right = 0;
      case (mode)
         0: c = pat;
         1: c = (n % 2 == 1) ? '0 : pat;
         2: begin
            r = n % W;
            v = int'(pat);
            v = ((v << r) | (v >> (W - r))) & ((1 << W) - 1);
            c = v[W-1:0];
         end
         default: begin
            for (int k = 0; k < n; k++) begin
               if (!right) begin
                  if (c[W-1]) begin right = 1; c = c >> 1; end
                  else c = c << 1;
               end else begin
                  if (c[0]) begin right = 0; c = c << 1; end
                  else c = c >> 1;
               end
            end
         end
      endcase
      return c;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [W-1:0] pat;
      int mode, per, steps, peff, raw, n;
      bit halted;
      logic [31:0] exp_status;

      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'd0;
      reset      = 1'b1;

      tbl[0]  = '{1'b0, 3'd0, 32'd0,         3'd0, 32'd0,          8'hFF};
      tbl[1]  = '{1'b0, 3'd0, 32'd0,         3'd1, 32'd50000000,   8'hFF};
      tbl[2]  = '{1'b0, 3'd0, 32'd0,         3'd2, 32'h000000FF,   8'hFF};
      tbl[3]  = '{1'b0, 3'd0, 32'd0,         3'd3, 32'd0,          8'hFF};
      tbl[4]  = '{1'b0, 3'd0, 32'd0,         3'd4, 32'h000000FF,   8'hFF};
      tbl[5]  = '{1'b0, 3'd0, 32'd0,         3'd5, 32'd0,          8'hFF};
      tbl[6]  = '{1'b0, 3'd0, 32'd0,         3'd7, 32'd0,          8'hFF};
      tbl[7]  = '{1'b1, 3'd2, 32'h000000A5,  3'd4, 32'h000000A5,   8'hA5};
      tbl[8]  = '{1'b0, 3'd0, 32'd0,         3'd2, 32'h000000A5,   8'hA5};
      tbl[9]  = '{1'b1, 3'd2, 32'h00000123,  3'd2, 32'h00000023,   8'h23};
      tbl[10] = '{1'b1, 3'd3, 32'hFFFFFFFF,  3'd3, 32'd0,          8'h23};
      tbl[11] = '{1'b1, 3'd4, 32'h00000055,  3'd4, 32'h00000023,   8'h23};
      tbl[12] = '{1'b1, 3'd5, 32'h0000DEAD,  3'd5, 32'd0,          8'h23};
      tbl[13] = '{1'b1, 3'd1, 32'd7,         3'd1, 32'd7,          8'h23};
      tbl[14] = '{1'b1, 3'd0, 32'h00030004,  3'd0, 32'h00030004,   8'h23};
      tbl[15] = '{1'b1, 3'd0, 32'h0000FFF8,  3'd0, 32'd0,          8'h23};
      tbl[16] = '{1'b0, 3'd0, 32'd0,         3'd3, 32'd0,          8'h23};

      cycle();
      cycle();
      reset = 1'b0;

      // register access table (starts from reset state)
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].do_wr) bus_write(tbl[i].wr_addr, tbl[i].wr_data);
         bus_read(tbl[i].rd_addr, rd);
         check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         check($sformatf("tbl%0d_led", i), {24'd0, out_port}, {24'd0, tbl[i].exp_led});
      end

      // ROTL, P=4, three steps then halt
      bus_write(3'd1, 32'd4);
      bus_write(3'd2, 32'h1);
      bus_write(3'd0, 32'h00030005);
      for (int t = 0; t < 16; t++) begin
         check($sformatf("rotl_t%0d", t), {24'd0, out_port},
               (t < 4) ? 32'h1 : (t < 8) ? 32'h2 : (t < 12) ? 32'h4 : 32'h8);
         cycle();
      end
      bus_read(3'd3, rd);
      check("rotl_status", rd, 32'h00030002);

      // PERIOD write mid-run restarts the step timer
      bus_write(3'd0, 32'h0);
      bus_write(3'd1, 32'd10);
      bus_write(3'd2, 32'h1);
      bus_write(3'd0, 32'h00000005);
      repeat (5) cycle();
      bus_write(3'd1, 32'd3);
      for (int t = 6; t < 10; t++) begin
         check($sformatf("period_t%0d", t), {24'd0, out_port}, (t < 9) ? 32'h1 : 32'h2);
         if (t < 9) cycle();
      end
      bus_write(3'd0, 32'h0);
      check("period_stop_led", {24'd0, out_port}, 32'h1);

      // BOUNCE, P=1, infinite
      bus_write(3'd2, 32'h40);
      bus_write(3'd1, 32'd1);
      bus_write(3'd0, 32'h00000007);
      exp_q = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
      for (int t = 0; t <= 10; t++) begin
         sb_check($sformatf("bounce_t%0d", t));
         if (t < 10) cycle();
      end
      bus_write(3'd0, 32'h0);
      check("bounce_stop_led", {24'd0, out_port}, 32'h40);
      bus_read(3'd3, rd);
      check("bounce_stop_busy", {31'd0, rd[0]}, 32'd0);

      // BLINK, P=2, then CTRL write colliding with a step
      bus_write(3'd2, 32'hF0);
      bus_write(3'd1, 32'd2);
      bus_write(3'd0, 32'h00000003);
      for (int t = 0; t < 6; t++) begin
         check($sformatf("blink_t%0d", t), {24'd0, out_port}, ((t / 2) % 2 == 1) ? 32'h0 : 32'hF0);
         if (t < 5) cycle();
      end
      bus_write(3'd0, 32'h00000003);
      check("blink_restart_led", {24'd0, out_port}, 32'hF0);
      bus_read(3'd3, rd);
      check("blink_restart_status", rd, 32'h00000001);
      cycle();
      check("blink_restart_t1", {24'd0, out_port}, 32'hF0);
      cycle();
      check("blink_restart_t2", {24'd0, out_port}, 32'h00);

      // PATTERN write colliding with a step: step uses old cur
      bus_write(3'd0, 32'h0);
      bus_write(3'd2, 32'h01);
      bus_write(3'd1, 32'd1);
      bus_write(3'd0, 32'h00000005);
      check("patcol_t0", {24'd0, out_port}, 32'h01);
      cycle();
      check("patcol_t1", {24'd0, out_port}, 32'h02);
      cycle();
      check("patcol_t2", {24'd0, out_port}, 32'h04);
      bus_write(3'd2, 32'h81);
      check("patcol_t3", {24'd0, out_port}, 32'h08);
      bus_read(3'd2, rd);
      check("patcol_pattern", rd, 32'h81);
      cycle();
      check("patcol_t4", {24'd0, out_port}, 32'h10);
      bus_write(3'd0, 32'h0);
      check("patcol_stop_led", {24'd0, out_port}, 32'h81);

      // randomized runs against the step-count model
      for (int run = 0; run < 20; run++) begin
         pat   = W'($urandom_range(0, 255));
         mode  = $urandom_range(0, 3);
         per   = $urandom_range(0, 4);
         steps = $urandom_range(0, 5);
         bus_write(3'd2, {24'd0, pat});
         check($sformatf("rnd%0d_idle_led", run), {24'd0, out_port}, {24'd0, pat});
         bus_write(3'd1, per);
         bus_write(3'd0, {16'(steps), 13'd0, 2'(mode), 1'b1});
         peff = (per == 0) ? 1 : per;
         for (int t = 0; t <= 24; t++) begin
            raw    = t / peff;
            halted = (steps != 0) && (raw >= steps);
            n      = halted ? steps : raw;
            exp_q.push_back(model_cur(mode, pat, n));
            sb_check($sformatf("rnd%0d_m%0d_p%0d_s%0d_t%0d", run, mode, per, steps, t));
            if (t == 24) begin
               exp_status = {16'(n), 14'd0, halted, !halted};
               bus_read(3'd3, rd);
               check($sformatf("rnd%0d_status", run), rd, exp_status);
            end else begin
               cycle();
            end
         end
         bus_write(3'd0, 32'h0);
         check($sformatf("rnd%0d_stop_led", run), {24'd0, out_port}, {24'd0, pat});
      end

      // reset mid-run with P=0
      bus_write(3'd2, 32'h03);
      bus_write(3'd1, 32'd0);
      bus_write(3'd0, 32'h00000005);
      check("rst_run_t0", {24'd0, out_port}, 32'h03);
      cycle();
      check("rst_run_t1", {24'd0, out_port}, 32'h06);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_led", {24'd0, out_port}, 32'hFF);
      bus_read(3'd0, rd);
      check("rst_ctrl", rd, 32'd0);
      bus_read(3'd1, rd);
      check("rst_period", rd, 32'd50000000);
      bus_read(3'd2, rd);
      check("rst_pattern", rd, 32'hFF);
      cycle();
      bus_read(3'd3, rd);
      check("rst_status", rd, 32'd0);
      bus_read(3'd4, rd);
      check("rst_current", rd, 32'hFF);
      repeat (3) cycle();
      check("rst_hold_led", {24'd0, out_port}, 32'hFF);
      bus_read(3'd3, rd);
      check("rst_hold_status", rd, 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
